mcu_tx_sched: RTL and testbench
===============================

MCU_TX_SCHED -- requirements
Module: mcu_tx_sched

Interface
REQ-001 Parameter NCH, default 4, is the number of requester channels (2..8).
REQ-002 Parameter W, default 24, is the command word width: {cmd[7:0], addr[7:0], data[7:0]}.
REQ-003 clk  in  1  single system clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 ch_wr  in  NCH  per-channel one-cycle write strobe.
REQ-006 ch_data  in  NCH*W  per-channel command word; channel i occupies bits [i*W +: W], sampled with ch_wr[i].
REQ-007 queue_di  out  W  word to the MCU TX FIFO.
REQ-008 queue_wr_req  out  1  FIFO write strobe, one cycle per word.
REQ-009 queue_wr_full  in  1  FIFO full.
REQ-010 queue_rd_empty  in  1  FIFO empty on the SPI read side.
REQ-011 ch_pending  out  NCH  per-channel pending-word flag.
REQ-012 ch_ovf  out  NCH  per-channel sticky overflow flag.
REQ-013 ovf_clr  in  1  one-cycle pulse; clears all ch_ovf bits.

Function
REQ-014 Each channel has a 1-deep holding register (pending flag plus word).
- ch_wr[i] with the pending flag clear loads the word and sets the flag at the next edge.
REQ-015 A ch_wr[i] while pending[i] is set and not granted in the same cycle:
- overwrites the held word with the new one;
- sets ch_ovf[i].
REQ-016 A ch_wr[i] in the same cycle that channel i is granted:
- loads the new word;
- keeps pending[i] set;
- does not set ch_ovf[i].
REQ-017 Grant is evaluated each cycle from the registered pending flags.
- At most one grant per cycle.
- Round-robin, starting at the channel after the last granted one.
- Pointer reset value selects channel 0 first.
REQ-018 When queue_wr_full is low and any pending flag is set:
- at the next edge, queue_wr_req = 1 and queue_di = the granted word;
- the granted pending flag clears;
- the round-robin pointer advances to that channel.
REQ-019 When queue_wr_full is high:
- no grant and queue_wr_req = 0;
- pending flags and the pointer hold.
REQ-020 Minimum latency from strobe to write is 2 edges: strobe at E0, queue_wr_req high after E1.
REQ-021 A single channel strobing every cycle with the FIFO not full loses no words and produces one write per cycle.
REQ-022 With all NCH channels pending, each channel is written exactly once within NCH consecutive non-full cycles.
REQ-023 queue_wr_req is never high for more than one cycle per granted word.
REQ-024 ovf_clr takes priority over a simultaneous overflow event: the bit reads 0 after that edge.

Reset
REQ-025 Reset clears all of the following asynchronously; none of it depends on clk:
- all pending flags, ch_ovf, queue_wr_req, queue_di (0);
- the round-robin pointer (points to NCH-1, so channel 0 is served first).
REQ-026 Reset mid-operation discards held words; no write is issued in the first cycle after reset release.

Configuration
REQ-027 Macro MCU_TX_NOPE_EN.
- Defined: when no flag is pending, queue_wr_full is low and queue_rd_empty is high, the next edge writes queue_di = {8'hFF, 16'h0000} with queue_wr_req = 1.
- A filler write does not move the pointer and is not repeated while queue_rd_empty stays high on consecutive cycles unless the previous filler was a write at least 2 cycles earlier.
- Undefined: no filler words; the FIFO is written only for channel data.

Structure
REQ-028 Package mcu_pkg holds:
- the CMD_* byte constants (CMD_NOPE = 8'hFF, CMD_RTC = 8'hFA, CMD_USB_UART = 8'hFC, CMD_ESP_UART = 8'hFB, CMD_FLASH = 8'hF9, CMD_DEBUG_ADDR = 8'h30, CMD_DEBUG_DATA = 8'h31);
- the W-bit command word typedef.
REQ-029 Round-robin selection is one sub-module, mcu_rr_arbiter (inputs: request vector, pointer, enable; outputs: one-hot grant and index).

Verification
REQ-030 ch_wr[1] = 1 with data 24'hFC0041, FIFO idle -> queue_wr_req high exactly 2 edges later with queue_di = 24'hFC0041; ch_ovf = 0.
REQ-031 All 4 channels strobed in the same cycle -> four consecutive writes in order 0,1,2,3; a second burst yields order 0,1,2,3 again.
REQ-032 queue_wr_full held high for 5 cycles with channel 2 pending:
- no writes during those cycles;
- ch_wr[2] again -> ch_ovf[2] = 1 and the later write carries the newer word;
- ovf_clr -> ch_ovf = 0.
REQ-033 Channel 0 strobed every cycle for 10 cycles, FIFO not full -> 10 writes, data in order, ch_ovf[0] = 0.
REQ-034 Reset asserted asynchronously mid-burst with 3 words pending -> outputs 0 immediately; after release no write until a new strobe.
REQ-035 MCU_TX_NOPE_EN defined, queue_rd_empty = 1, no requests -> filler word 24'hFF0000 written; undefined -> queue_wr_req stays 0.

Source files
------------

// File: rtl/mcu_pkg.sv
// Shared command byte constants and the MCU command word type.
package mcu_pkg;

    localparam int CMD_WORD_W = 24;

    typedef logic [CMD_WORD_W-1:0] cmd_word_t;

    localparam logic [7:0] CMD_NOPE       = 8'hFF;
    localparam logic [7:0] CMD_RTC        = 8'hFA;
    localparam logic [7:0] CMD_USB_UART   = 8'hFC;
    localparam logic [7:0] CMD_ESP_UART   = 8'hFB;
    localparam logic [7:0] CMD_FLASH      = 8'hF9;
    localparam logic [7:0] CMD_DEBUG_ADDR = 8'h30;
    localparam logic [7:0] CMD_DEBUG_DATA = 8'h31;

    function automatic cmd_word_t nope_word();
        return {CMD_NOPE, 8'h00, 8'h00};
    endfunction

endpackage

// File: rtl/mcu_rr_arbiter.sv
// Round-robin arbiter: search starts at the channel after ptr, one grant at most.
module mcu_rr_arbiter
    import mcu_pkg::*;
#(
    parameter int NCH = 4,
    parameter int PW  = $clog2(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [PW-1:0]  ptr,
    input  logic           en,
    output logic [NCH-1:0] grant,
    output logic [PW-1:0]  idx
);

    logic [PW-1:0] cand_s;
    logic          found_s;

    // Walk channels ptr+1 .. ptr+NCH (mod NCH) and take the first requester.
    always_comb begin
        grant   = '0;
        idx     = '0;
        found_s = 1'b0;
        cand_s  = '0;
        for (int k = 1; k <= NCH; k++) begin
            cand_s = PW'((int'(ptr) + k) % NCH);
            if (en && req[cand_s] && !found_s) begin
                grant[cand_s] = 1'b1;
                idx           = cand_s;
                found_s       = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/mcu_tx_sched.sv
// Per-channel holding registers feeding the MCU TX FIFO through a round-robin arbiter.
// Optional filler (NOPE) words when idle are enabled by MCU_TX_NOPE_EN.
module mcu_tx_sched
    import mcu_pkg::*;
#(
    parameter int NCH = 4,
    parameter int W   = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NCH-1:0]   ch_wr,
    input  logic [NCH*W-1:0] ch_data,
    output logic [W-1:0]     queue_di,
    output logic             queue_wr_req,
    input  logic             queue_wr_full,
    input  logic             queue_rd_empty,
    output logic [NCH-1:0]   ch_pending,
    output logic [NCH-1:0]   ch_ovf,
    input  logic             ovf_clr
);

    localparam int PW = $clog2(NCH);

    logic [NCH-1:0] pending_r;
    logic [NCH-1:0] ovf_r;
    logic [W-1:0]   word_r [NCH];
    logic [PW-1:0]  ptr_r;

    logic [NCH-1:0] grant_s;
    logic [PW-1:0]  idx_s;
    logic           any_grant_s;
    logic           nope_s;
    logic [NCH-1:0] pend_nxt_s;
    logic [NCH-1:0] ovf_nxt_s;
    logic [W-1:0]   word_nxt_s [NCH];

    mcu_rr_arbiter #(.NCH(NCH), .PW(PW)) u_arb (
        .req   (pending_r),
        .ptr   (ptr_r),
        .en    (~queue_wr_full),
        .grant (grant_s),
        .idx   (idx_s)
    );

    assign any_grant_s = |grant_s;

`ifdef MCU_TX_NOPE_EN
    logic nope_last_r;

    // Filler only when idle; never on two consecutive cycles.
    always_comb begin
        nope_s = ~|pending_r & ~queue_wr_full & queue_rd_empty & ~nope_last_r;
    end

    // Remember whether the previous cycle issued a filler.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nope_last_r <= 1'b0;
        end else begin
            nope_last_r <= nope_s;
        end
    end
`else
    logic unused_rd_empty_s;
    assign unused_rd_empty_s = queue_rd_empty;

    // Filler disabled: the FIFO only ever sees channel data.
    always_comb begin
        nope_s = 1'b0;
    end
`endif

    // Holding register next state; a write in the grant cycle refills without overflow.
    always_comb begin
        pend_nxt_s = '0;
        ovf_nxt_s  = '0;
        for (int i = 0; i < NCH; i++) begin
            word_nxt_s[i] = ch_wr[i] ? ch_data[i*W +: W] : word_r[i];
            pend_nxt_s[i] = ch_wr[i] | (pending_r[i] & ~grant_s[i]);
            ovf_nxt_s[i]  = ovf_clr ? 1'b0
                                    : (ovf_r[i] | (ch_wr[i] & pending_r[i] & ~grant_s[i]));
        end
    end

    // Channel state, pointer and FIFO write port registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_r    <= '0;
            ovf_r        <= '0;
            ptr_r        <= PW'(NCH - 1);
            queue_wr_req <= 1'b0;
            queue_di     <= '0;
            for (int i = 0; i < NCH; i++) begin
                word_r[i] <= '0;
            end
        end else begin
            pending_r    <= pend_nxt_s;
            ovf_r        <= ovf_nxt_s;
            ptr_r        <= any_grant_s ? idx_s : ptr_r;
            queue_wr_req <= any_grant_s | nope_s;
            queue_di     <= any_grant_s ? word_r[idx_s]
                          : (nope_s ? W'(nope_word()) : queue_di);
            for (int i = 0; i < NCH; i++) begin
                word_r[i] <= word_nxt_s[i];
            end
        end
    end

    assign ch_pending = pending_r;
    assign ch_ovf     = ovf_r;

endmodule

// File: tb/tb_mcu_tx_sched.sv
// Directed self-checking bench for mcu_tx_sched (NCH=4, W=24).
module tb_mcu_tx_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  ch_wr;
    logic [95:0] ch_data;
    logic [23:0] queue_di;
    logic        queue_wr_req;
    logic        queue_wr_full;
    logic        queue_rd_empty;
    logic [3:0]  ch_pending;
    logic [3:0]  ch_ovf;
    logic        ovf_clr;

    int checks   = 0;
    int failures = 0;

    logic [23:0] bw [4];

    mcu_tx_sched #(.NCH(4), .W(24)) dut (
        .clk            (clk),
        .reset          (reset),
        .ch_wr          (ch_wr),
        .ch_data        (ch_data),
        .queue_di       (queue_di),
        .queue_wr_req   (queue_wr_req),
        .queue_wr_full  (queue_wr_full),
        .queue_rd_empty (queue_rd_empty),
        .ch_pending     (ch_pending),
        .ch_ovf         (ch_ovf),
        .ovf_clr        (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_write(input string tag, input logic [23:0] exp_di);
        chk({tag, "_req"}, {31'd0, queue_wr_req}, 32'd1);
        chk({tag, "_di"}, {8'd0, queue_di}, {8'd0, exp_di});
    endtask

    initial begin
        reset          = 1'b1;
        ch_wr          = 4'b0000;
        ch_data        = 96'd0;
        queue_wr_full  = 1'b0;
        queue_rd_empty = 1'b0;
        ovf_clr        = 1'b0;
        bw[0] = 24'hFA0011;
        bw[1] = 24'hFC0122;
        bw[2] = 24'hFB0233;
        bw[3] = 24'hF90344;

        tick();
        tick();
        chk("rst_req", {31'd0, queue_wr_req}, 32'd0);
        chk("rst_di", {8'd0, queue_di}, 32'd0);
        chk("rst_pend", {28'd0, ch_pending}, 32'd0);
        chk("rst_ovf", {28'd0, ch_ovf}, 32'd0);
        reset = 1'b0;
        tick();
        chk("post_rst_idle", {31'd0, queue_wr_req}, 32'd0);

        // Two bursts with all channels strobed together: order 0,1,2,3 each time.
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 4; i++) ch_data[i*24 +: 24] = bw[i] ^ {16'd0, 8'(b)};
            ch_wr = 4'b1111;
            tick();
            ch_wr = 4'b0000;
            chk("burst_pend", {28'd0, ch_pending}, 32'hF);
            chk("burst_nowr", {31'd0, queue_wr_req}, 32'd0);
            for (int i = 0; i < 4; i++) begin
                tick();
                chk_write($sformatf("burst%0d_ch%0d", b, i), bw[i] ^ {16'd0, 8'(b)});
            end
            tick();
            chk("burst_end", {31'd0, queue_wr_req}, 32'd0);
        end

        // Single write on channel 1: strobe at E0, write visible after E1.
        ch_data[1*24 +: 24] = 24'hFC0041;
        ch_wr = 4'b0010;
        tick();
        ch_wr = 4'b0000;
        chk("lat_e0_req", {31'd0, queue_wr_req}, 32'd0);
        chk("lat_e0_pend", {28'd0, ch_pending}, 32'h2);
        tick();
        chk_write("lat_e1", 24'hFC0041);
        chk("lat_pend_clr", {28'd0, ch_pending}, 32'h0);
        tick();
        chk("lat_single", {31'd0, queue_wr_req}, 32'd0);
        chk("lat_ovf", {28'd0, ch_ovf}, 32'h0);

        // FIFO full with channel 2 pending; second strobe overwrites and flags overflow.
        queue_wr_full = 1'b1;
        ch_data[2*24 +: 24] = 24'hFB00A1;
        ch_wr = 4'b0100;
        tick();
        ch_wr = 4'b0000;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                ch_data[2*24 +: 24] = 24'hFB00A2;
                ch_wr = 4'b0100;
            end else begin
                ch_wr = 4'b0000;
            end
            tick();
            chk($sformatf("full_nowr%0d", c), {31'd0, queue_wr_req}, 32'd0);
        end
        ch_wr = 4'b0000;
        chk("full_pend_hold", {28'd0, ch_pending}, 32'h4);
        chk("full_ovf", {28'd0, ch_ovf}, 32'h4);
        queue_wr_full = 1'b0;
        tick();
        chk_write("full_newer", 24'hFB00A2);
        chk("full_ovf_sticky", {28'd0, ch_ovf}, 32'h4);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_cleared", {28'd0, ch_ovf}, 32'h0);

        // Overflow and ovf_clr in the same cycle: clear wins.
        queue_wr_full = 1'b1;
        ch_data[2*24 +: 24] = 24'hFB00B3;
        ch_wr = 4'b0100;
        tick();
        ch_data[2*24 +: 24] = 24'hFB00B4;
        ovf_clr = 1'b1;
        tick();
        ch_wr = 4'b0000;
        ovf_clr = 1'b0;
        chk("clr_priority", {28'd0, ch_ovf}, 32'h0);
        queue_wr_full = 1'b0;
        tick();
        chk_write("clr_prio_wr", 24'hFB00B4);

        // Channel 0 strobed every cycle: one write per cycle, nothing lost.
        for (int k = 0; k < 10; k++) begin
            ch_data[0 +: 24] = {8'h31, 8'h00, 8'(k)};
            ch_wr = 4'b0001;
            tick();
            if (k > 0) chk_write($sformatf("stream%0d", k - 1), {8'h31, 8'h00, 8'(k - 1)});
        end
        ch_wr = 4'b0000;
        tick();
        chk_write("stream9", 24'h310009);
        tick();
        chk("stream_end", {31'd0, queue_wr_req}, 32'd0);
        chk("stream_ovf", {28'd0, ch_ovf}, 32'h0);

        // Async reset mid-burst with three words still pending.
        for (int i = 0; i < 4; i++) ch_data[i*24 +: 24] = bw[i];
        ch_wr = 4'b1111;
        tick();
        ch_wr = 4'b0000;
        tick();
        chk_write("pre_rst_wr", bw[1]);
        chk("pre_rst_pend", {28'd0, ch_pending}, 32'hD);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_req", {31'd0, queue_wr_req}, 32'd0);
        chk("async_rst_di", {8'd0, queue_di}, 32'd0);
        chk("async_rst_pend", {28'd0, ch_pending}, 32'd0);
        tick();
        #2 reset = 1'b0;
        tick();
        chk("rel_nowr0", {31'd0, queue_wr_req}, 32'd0);
        tick();
        chk("rel_nowr1", {31'd0, queue_wr_req}, 32'd0);
        ch_data[0 +: 24]  = 24'h300077;
        ch_data[48 +: 24] = 24'h310088;
        ch_wr = 4'b0101;
        tick();
        ch_wr = 4'b0000;
        tick();
        chk_write("rel_ch0_first", 24'h300077);
        tick();
        chk_write("rel_ch2", 24'h310088);
        tick();
        chk("rel_done", {31'd0, queue_wr_req}, 32'd0);

        // Idle with the SPI side empty: filler words only when enabled.
        queue_rd_empty = 1'b1;
        tick();
`ifdef MCU_TX_NOPE_EN
        chk_write("nope0", 24'hFF0000);
        tick();
        chk("nope_gap", {31'd0, queue_wr_req}, 32'd0);
        tick();
        chk_write("nope1", 24'hFF0000);
`else
        chk("nope_off0", {31'd0, queue_wr_req}, 32'd0);
        tick();
        chk("nope_off1", {31'd0, queue_wr_req}, 32'd0);
        tick();
        chk("nope_off2", {31'd0, queue_wr_req}, 32'd0);
`endif
        queue_rd_empty = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
